// File: rtl/alarm_trigger_pkg.sv
// alarm_trigger_pkg: state encodings, time-field widths and helpers for the alarm controller
package alarm_trigger_pkg;
    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RING   = 2'b01,
        ST_SNOOZE = 2'b10
    } state_t;
    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/alarm_tick_gen.sv
// alarm_tick_gen: one-cycle sec_tick every TICKS_PER_SEC cycles, restartable by clr
module alarm_tick_gen #(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic clk_in,
    input  logic rst,
    input  logic clr,
    output logic sec_tick
);
    localparam int W = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
    logic [W-1:0] cnt;
    assign sec_tick = cnt == W'(TICKS_PER_SEC - 1);
    always_ff @(posedge clk_in) begin
        if (rst || clr || sec_tick) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/alarm_trigger.sv
// alarm_trigger: alarm FSM comparing clock time to alarm time, with stop, snooze, ring timeout
module alarm_trigger
    import alarm_trigger_pkg::*;
#(
    parameter int TICKS_PER_SEC    = 100_000_000,
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int SNOOZE_MIN       = 5,
    parameter int MAX_SNOOZE       = 3
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [SEC_W-1:0]  cur_sec,
    input  logic [HOUR_W-1:0] alm_hour,
    input  logic [MIN_W-1:0]  alm_min,
    input  logic              alm_on,
    input  logic              btn_stop,
    input  logic              btn_snooze,
    output logic              siren_enb,
    output logic              snoozing,
    output logic [1:0]        snooze_cnt
);
    localparam int SNOOZE_SEC = SNOOZE_MIN * 60;
    localparam int SW = $clog2(max2(RING_TIMEOUT_SEC, SNOOZE_SEC) + 1);
    state_t        state, nxt;
    logic          match, match_q, fire, sec_tick, clr, ring_done, snz_done;
    logic [SW-1:0] sec_cnt;
    assign match     = alm_on && cur_hour == alm_hour && cur_min == alm_min && cur_sec == '0;
    assign fire      = match && !match_q;
    assign ring_done = sec_tick && sec_cnt == SW'(RING_TIMEOUT_SEC - 1);
    assign snz_done  = sec_tick && sec_cnt == SW'(SNOOZE_SEC - 1);
    // Restart the timebase on every state change so dwell times are whole seconds
    assign clr       = nxt != state;
    assign siren_enb = state == ST_RING;
    assign snoozing  = state == ST_SNOOZE;
    alarm_tick_gen #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick (
        .clk_in  (clk_in),
        .rst     (rst),
        .clr     (clr),
        .sec_tick(sec_tick)
    );
    always_comb begin
        nxt = ST_IDLE;
        if (alm_on)
            case (state)
                ST_IDLE:   nxt = fire ? ST_RING : ST_IDLE;
                ST_RING:   nxt = btn_stop ? ST_IDLE :
                                 (btn_snooze && snooze_cnt < 2'(MAX_SNOOZE)) ? ST_SNOOZE :
                                 ring_done ? ST_IDLE : ST_RING;
                ST_SNOOZE: nxt = btn_stop ? ST_IDLE : snz_done ? ST_RING : ST_SNOOZE;
                default:   nxt = ST_IDLE;
            endcase
    end
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state      <= ST_IDLE;
            match_q    <= 1'b1;
            sec_cnt    <= '0;
            snooze_cnt <= '0;
        end else begin
            state      <= nxt;
            match_q    <= match;
            sec_cnt    <= (clr || state == ST_IDLE) ? '0 : sec_tick ? sec_cnt + 1'b1 : sec_cnt;
            snooze_cnt <= nxt == ST_IDLE ? '0 :
                          (state == ST_RING && nxt == ST_SNOOZE) ? snooze_cnt + 2'd1 : snooze_cnt;
        end
    end
endmodule

// File: tb/tb_alarm_trigger.sv
// tb_alarm_trigger: directed test-plan scenarios plus random stimulus against a cycle-count model
module tb_alarm_trigger;
    localparam int TPS = 10, RT = 5, SNZ = 1, MAXS = 2;
    localparam int RING_CYC = RT * TPS, SNZ_CYC = SNZ * 60 * TPS;
    logic       clk_in = 0, rst = 1, alm_on = 1, btn_stop = 0, btn_snooze = 0;
    logic [4:0] cur_hour = 5'd7, alm_hour = 5'd7;
    logic [5:0] cur_min = 6'd29, cur_sec = 6'd59, alm_min = 6'd30;
    logic       siren_enb, snoozing;
    logic [1:0] snooze_cnt;
    int         tests = 0, fails = 0, n;
    int         m_mode = 0, m_el = 0, m_cnt = 0;
    bit         m_prev = 1;

    alarm_trigger #(
        .TICKS_PER_SEC(TPS), .RING_TIMEOUT_SEC(RT), .SNOOZE_MIN(SNZ), .MAX_SNOOZE(MAXS)
    ) dut (
        .clk_in(clk_in), .rst(rst), .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .alm_hour(alm_hour), .alm_min(alm_min), .alm_on(alm_on), .btn_stop(btn_stop),
        .btn_snooze(btn_snooze), .siren_enb(siren_enb), .snoozing(snoozing), .snooze_cnt(snooze_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Model: mode 0 idle, 1 ringing, 2 snoozing; m_el = cycles already spent in current mode
    task automatic step();
        bit mt;
        int nm;
        mt = alm_on && cur_hour == alm_hour && cur_min == alm_min && cur_sec == 0;
        if (rst) begin
            m_mode = 0; m_el = 0; m_cnt = 0; m_prev = 1;
        end else begin
            nm = m_mode;
            if (!alm_on) nm = 0;
            else if (m_mode == 0) nm = (mt && !m_prev) ? 1 : 0;
            else if (m_mode == 1) begin
                if (btn_stop) nm = 0;
                else if (btn_snooze && m_cnt < MAXS) begin nm = 2; m_cnt++; end
                else if (m_el + 1 == RING_CYC) nm = 0;
            end else begin
                if (btn_stop) nm = 0;
                else if (m_el + 1 == SNZ_CYC) nm = 1;
            end
            if (nm == 0) m_cnt = 0;
            m_el = (nm == m_mode) ? m_el + 1 : 0;
            m_mode = nm;
            m_prev = mt;
        end
        @(posedge clk_in);
        #1;
        check("siren_enb", siren_enb, m_mode == 1);
        check("snoozing", snoozing, m_mode == 2);
        check("snooze_cnt", snooze_cnt, m_cnt);
        btn_stop = 0;
        btn_snooze = 0;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
    endtask

    task automatic fire_alarm();
        set_time(7, 29, 59);
        step();
        set_time(7, 30, 0);
        step();
    endtask

    initial begin
        step(); step();
        check("rst_siren", siren_enb, 0);
        check("rst_cnt", snooze_cnt, 0);
        rst = 0;
        step();
        // full uninterrupted ring
        fire_alarm();
        n = 0;
        for (int i = 0; i < 100 && siren_enb; i++) begin n++; step(); end
        check("ring_len", n, 50);
        // stop at N+20, match held, no re-fire
        fire_alarm();
        repeat (19) step();
        btn_stop = 1;
        step();
        check("stop", siren_enb, 0);
        repeat (30) step();
        check("no_refire", siren_enb, 0);
        // snooze at N+10, exact 600-cycle snooze
        fire_alarm();
        repeat (9) step();
        btn_snooze = 1;
        step();
        n = 0;
        for (int i = 0; i < 700 && snoozing; i++) begin n++; step(); end
        check("snooze_len", n, 600);
        check("resume_ring", siren_enb, 1);
        check("snooze_cnt1", snooze_cnt, 1);
        // second snooze, then third ignored, then timeout
        repeat (3) step();
        btn_snooze = 1;
        step();
        repeat (600) step();
        btn_snooze = 1;
        step();
        check("snz_ignored", siren_enb, 1);
        check("snooze_cnt2", snooze_cnt, 2);
        repeat (60) step();
        check("timeout_idle", siren_enb, 0);
        check("cnt_cleared", snooze_cnt, 0);
        // stop and snooze together
        fire_alarm();
        step();
        btn_stop = 1;
        btn_snooze = 1;
        step();
        check("both_btn", siren_enb, 0);
        check("both_cnt", snooze_cnt, 0);
        // alm_on drop during snooze
        fire_alarm();
        btn_snooze = 1;
        step();
        alm_on = 0;
        step();
        check("almoff_snz", snoozing, 0);
        alm_on = 1;
        step();
        // reset mid-ring, no re-fire, next day fires
        fire_alarm();
        repeat (5) step();
        rst = 1;
        step();
        rst = 0;
        check("rst_mid", siren_enb, 0);
        repeat (30) step();
        check("rst_norefire", siren_enb, 0);
        set_time(7, 30, 1);
        step();
        set_time(7, 30, 0);
        step();
        check("next_day", siren_enb, 1);
        // random stimulus
        for (int i = 0; i < 3000; i++) begin
            n = $urandom_range(0, 99);
            if (n < 8) set_time(7, 30, 0);
            else if (n >= 40) set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            btn_stop   = $urandom_range(0, 59) == 0;
            btn_snooze = $urandom_range(0, 19) == 0;
            alm_on     = $urandom_range(0, 299) != 0;
            rst        = $urandom_range(0, 999) == 0;
            step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
